// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light phase FSM and its countdown display.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2,
    ST_FAULT  = 2'd3
  } phase_t;

  localparam int DEF_GREEN_LEN    = 15;
  localparam int DEF_YELLOW_LEN   = 5;
  localparam int DEF_RED_LEN      = 10;
  localparam int DEF_BLINK_THRESH = 3;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit enables, active-low: [0] ones, [1] tens.
  localparam logic [1:0] DIG_OFF  = 2'b11;
  localparam logic [1:0] DIG_ONES = 2'b10;
  localparam logic [1:0] DIG_TENS = 2'b01;

  typedef enum logic [1:0] {
    SHOW_O  = 2'd0,
    BLANK_O = 2'd1,
    SHOW_T  = 2'd2,
    BLANK_T = 2'd3
  } scan_state_t;

endpackage

// File: rtl/countdown_disp_if.sv
// Phase inputs from the traffic FSM and the multiplexed 7-segment outputs.
// sec_tick/scan_tick are single-cycle enables: no valid/ready handshake; the
// consumer samples them on every clk edge and never back-pressures the source.
interface countdown_disp_if;
  logic       sec_tick;
  logic       scan_tick;
  logic [1:0] state;
  logic [3:0] count;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [1:0] digit_en;

  modport master (
    output sec_tick, scan_tick, state, count,
    input  seg_out, dp_out, digit_en
  );

  modport slave (
    input  sec_tick, scan_tick, state, count,
    output seg_out, dp_out, digit_en
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a}; codes above 9 are blank.
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_disp.sv
// Two-digit countdown of seconds left in the current traffic phase.
// Optional COUNTDOWN_DP_HEARTBEAT_EN: ones-digit decimal point follows blink_phase.
module countdown_disp
  import traffic_pkg::*;
#(
  parameter int GREEN_LEN    = DEF_GREEN_LEN,
  parameter int YELLOW_LEN   = DEF_YELLOW_LEN,
  parameter int RED_LEN      = DEF_RED_LEN,
  parameter int BLINK_THRESH = DEF_BLINK_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  countdown_disp_if.slave  bus,
  output scan_state_t      dbg_scan_state
);

  logic [4:0] len_sel;
  logic [4:0] count_x;
  logic [4:0] remaining;
  logic       fault;
  logic       blink_phase;

  always_comb begin
    count_x = {1'b0, bus.count};
    unique case (phase_t'(bus.state))
      ST_GREEN:  len_sel = 5'(GREEN_LEN);
      ST_YELLOW: len_sel = 5'(YELLOW_LEN);
      ST_RED:    len_sel = 5'(RED_LEN);
      ST_FAULT:  len_sel = 5'd0;
    endcase
  end

  // Latch stage: capture the phase snapshot once per second.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining   <= 5'd0;
      fault       <= 1'b0;
      blink_phase <= 1'b0;
    end else if (bus.sec_tick) begin
      blink_phase <= ~blink_phase;
      if (phase_t'(bus.state) == ST_FAULT) begin
        fault     <= 1'b1;
        remaining <= 5'd0;
      end else begin
        fault     <= 1'b0;
        remaining <= (count_x > len_sel) ? 5'd0 : (len_sel - count_x);
      end
    end
  end

  logic [3:0] tens;
  logic [3:0] ones;
  logic       fault_q;
  logic       blank_q;
`ifdef COUNTDOWN_DP_HEARTBEAT_EN
  logic       hb_q;
`endif

  // BCD stage: split and flag blinking one cycle after the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens    <= 4'd0;
      ones    <= 4'd0;
      fault_q <= 1'b0;
      blank_q <= 1'b0;
`ifdef COUNTDOWN_DP_HEARTBEAT_EN
      hb_q    <= 1'b0;
`endif
    end else begin
      tens    <= 4'(remaining / 5'd10);
      ones    <= 4'(remaining % 5'd10);
      fault_q <= fault;
      blank_q <= blink_phase && (remaining != 5'd0) && (remaining <= 5'(BLINK_THRESH));
`ifdef COUNTDOWN_DP_HEARTBEAT_EN
      hb_q    <= blink_phase;
`endif
    end
  end

  logic [6:0] ones_raw;
  logic [6:0] tens_raw;
  logic [6:0] ones_pat;
  logic [6:0] tens_pat;

  seg7_decode u_dec_ones (.bcd(ones), .seg(ones_raw));
  seg7_decode u_dec_tens (.bcd(tens), .seg(tens_raw));

  always_comb begin
    ones_pat = ones_raw;
    tens_pat = (tens == 4'd0) ? SEG_BLANK : tens_raw;
    if (fault_q) begin
      ones_pat = SEG_DASH;
      tens_pat = SEG_DASH;
    end else if (blank_q) begin
      ones_pat = SEG_BLANK;
      tens_pat = SEG_BLANK;
    end
  end

  scan_state_t scan_state;
  logic [6:0]  seg_r;
  logic        dp_r;
  logic [1:0]  en_r;

  // Outputs are loaded on the transition into each state and held there.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_state <= BLANK_T;
      seg_r      <= SEG_BLANK;
      dp_r       <= 1'b1;
      en_r       <= DIG_OFF;
    end else begin
      unique case (scan_state)
        SHOW_O: if (bus.scan_tick) begin
          scan_state <= BLANK_O;
          seg_r      <= SEG_BLANK;
          dp_r       <= 1'b1;
          en_r       <= DIG_OFF;
        end
        BLANK_O: begin
          scan_state <= SHOW_T;
          seg_r      <= tens_pat;
          dp_r       <= 1'b1;
          en_r       <= DIG_TENS;
        end
        SHOW_T: if (bus.scan_tick) begin
          scan_state <= BLANK_T;
          seg_r      <= SEG_BLANK;
          dp_r       <= 1'b1;
          en_r       <= DIG_OFF;
        end
        BLANK_T: begin
          scan_state <= SHOW_O;
          seg_r      <= ones_pat;
`ifdef COUNTDOWN_DP_HEARTBEAT_EN
          dp_r       <= ~hb_q;
`else
          dp_r       <= 1'b1;
`endif
          en_r       <= DIG_ONES;
        end
      endcase
    end
  end

  assign bus.seg_out    = seg_r;
  assign bus.dp_out     = dp_r;
  assign bus.digit_en   = en_r;
  assign dbg_scan_state = scan_state;

endmodule

// File: tb/tb_countdown_disp.sv
// Randomized bench for countdown_disp against a per-second snapshot model.
module tb_countdown_disp;
  import traffic_pkg::*;

  localparam int W = 39;  // {edge[31:0], remaining[4:0], fault, blink_phase}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_disp_if bus();
  scan_state_t dbg_scan_state;

  countdown_disp dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .dbg_scan_state (dbg_scan_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  string scen  = "init";

  logic [W-1:0] exp_q[$];
  int           pos = 3;       // ring: 0 show ones, 1 blank, 2 show tens, 3 blank
  int           tick_total = 0;
  logic [6:0]   exp_seg = 7'h7F;
  logic [1:0]   exp_en  = 2'b11;
  logic         exp_dp  = 1'b1;
  logic [6:0]   seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h expected 0x%0h (cycle %0d)", scen, tag, got, exp, cyc);
  endtask

  function automatic int phase_len(input int st);
    case (st)
      0: return 15;
      1: return 5;
      2: return 10;
      default: return 0;
    endcase
  endfunction

  // Advance the reference by one clk edge whose sampled inputs are given.
  task automatic model_edge(input logic rst, input logic sec, input logic scan,
                            input int st, input int cnt);
    int new_pos;
    int rem;
    logic flt;
    logic ph;
    logic blink;
    logic [W-1:0] rec;
    if (rst) begin
      pos = 3;
      exp_q.delete();
      tick_total = 0;
      exp_seg = 7'h7F;
      exp_en  = 2'b11;
      exp_dp  = 1'b1;
      return;
    end
    new_pos = pos;
    if (pos == 1 || pos == 3) new_pos = (pos + 1) % 4;
    else if (scan) new_pos = pos + 1;
    if (new_pos != pos) begin
      if (new_pos == 1 || new_pos == 3) begin
        exp_seg = 7'h7F;
        exp_en  = 2'b11;
        exp_dp  = 1'b1;
      end else begin
        // A digit shows the newest second latched at least two edges earlier.
        rem = 0; flt = 1'b0; ph = 1'b0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          rec = exp_q[i];
          if (int'(rec[38:7]) <= cyc - 2) begin
            rem = int'(rec[6:2]); flt = rec[1]; ph = rec[0];
            break;
          end
        end
        blink = !flt && rem >= 1 && rem <= 3 && ph;
        exp_dp = 1'b1;
        if (new_pos == 0) begin
          exp_en  = 2'b10;
          exp_seg = flt ? SEG_DASH : blink ? 7'h7F : seg_ref[rem % 10];
`ifdef COUNTDOWN_DP_HEARTBEAT_EN
          exp_dp  = ~ph;
`endif
        end else begin
          exp_en  = 2'b01;
          exp_seg = flt ? SEG_DASH : blink ? 7'h7F : (rem / 10 == 0) ? 7'h7F : seg_ref[rem / 10];
        end
      end
      pos = new_pos;
    end
    if (sec) begin
      tick_total++;
      flt = (st == 3);
      rem = flt ? 0 : (cnt > phase_len(st)) ? 0 : phase_len(st) - cnt;
      exp_q.push_back({32'(cyc), 5'(rem), flt, 1'(tick_total % 2)});
    end
  endtask

  task automatic step(input logic rst, input logic sec, input logic scan,
                      input logic [1:0] st, input logic [3:0] cnt);
    reset         = rst;
    bus.sec_tick  = sec;
    bus.scan_tick = scan;
    bus.state     = st;
    bus.count     = cnt;
    @(posedge clk);
    cyc++;
    model_edge(rst, sec, scan, int'(st), int'(cnt));
    #1;
    check_eq("seg_out",  8'(bus.seg_out),  8'(exp_seg));
    check_eq("digit_en", 8'(bus.digit_en), 8'(exp_en));
    check_eq("dp_out",   8'(bus.dp_out),   8'(exp_dp));
  endtask

  // Several seconds of one phase: a sec_tick, then scanning with gaps.
  task automatic phase_run(input string name, input logic [1:0] st, input logic [3:0] cnt,
                           input int seconds, input int scan_every);
    scen = name;
    for (int s = 0; s < seconds; s++) begin
      step(1'b0, 1'b1, 1'b0, st, cnt);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, (i % scan_every) == 0, st, cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.sec_tick = 1'b0; bus.scan_tick = 1'b0; bus.state = 2'd0; bus.count = 4'd0;

    scen = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 2'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    phase_run("countdown", 2'd0, 4'd3,  2, 4);
    phase_run("blink",     2'd1, 4'd3,  6, 3);
    phase_run("zero",      2'd1, 4'd5,  4, 3);
    phase_run("saturate",  2'd2, 4'd14, 3, 3);
    phase_run("fault",     2'd3, 4'd0,  4, 3);

    scen = "coincide";
    for (int i = 0; i < 24; i++) step(1'b0, (i % 5) == 0, 1'b1, 2'd0, 4'(13 - i / 5));
    for (int i = 0; i < 24; i++) step(1'b0, (i % 3) == 0, (i % 2) == 0, 2'd1, 4'(i % 6));

    scen = "random";
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
